capture_ctrl_gen2: RTL and testbench

CAPTURE_CTRL_GEN2 -- requirements
Module: capture_ctrl_gen2

---
 rtl/capture_ctrl_gen2_if.sv | 19 +
 rtl/capture_ctrl_gen2.sv | 181 ++++++++++++++++++
 tb/tb_capture_ctrl_gen2.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_gen2_if.sv
// Write-side bus of the capture controller: RAM write port plus capture status.
interface capture_ctrl_gen2_if #(
  parameter int AW = 9
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          armed;
  logic          set_capture_done;
  logic          busy;

  modport master (
    output we, waddr, trig_addr, armed, set_capture_done, busy
  );

  modport slave (
    input we, waddr, trig_addr, armed, set_capture_done, busy
  );
endinterface

// File: rtl/capture_ctrl_gen2.sv
// Circular-buffer capture controller: pre-trigger fill, trigger, post-trigger count.
// Optional sample decimation is enabled by defining CAPTURE_DECIM_EN.
module capture_ctrl_gen2 #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9,
  parameter int PW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          run,
  input  logic          auto_rearm,
  input  logic          triggered,
  input  logic          capture_done,
  input  logic [PW-1:0] trig_pos,
`ifdef CAPTURE_DECIM_EN
  input  logic [3:0]    decim,
`endif
  capture_ctrl_gen2_if.master cap
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [16:0]   ENT17 = 17'(ENTRIES);
  localparam logic [AW-1:0] LAST  = AW'(ENTRIES - 1);

  // Post-trigger length clamped into 1..ENTRIES.
  function automatic logic [16:0] clamp_post(input logic [PW-1:0] tp);
    logic [31:0] tp32;
    tp32 = 32'(tp);
    if (tp32 == 32'd0)
      return 17'd1;
    else if (tp32 >= 32'(ENTRIES))
      return ENT17;
    else
      return 17'(tp32);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + AW'(1);
  endfunction

  state_t        state, state_next;
  logic [AW-1:0] waddr, trig_addr;
  logic          armed;
  logic [15:0]   pre_cnt, post_cnt;
  logic [16:0]   p_eff, q_eff;
  logic          strb;
  logic          busy_c, we_c, done_c;
  logic          trig_acc, pre_hit, post_hit;

  assign p_eff    = clamp_post(trig_pos);
  assign q_eff    = ENT17 - p_eff;
  assign pre_hit  = ({1'b0, pre_cnt} + 17'd1) >= q_eff;
  assign post_hit = ({1'b0, post_cnt} + 17'd1) >= p_eff;
  // An abort in the same cycle suppresses the trigger.
  assign trig_acc = (state == S_ARMED) && run && triggered && we_c;

`ifdef CAPTURE_DECIM_EN
  logic [3:0] div_cnt;
  logic       pre_entry;

  assign pre_entry = (state_next == S_PRE) && (state != S_PRE);
  assign strb      = wrt_smpl && (div_cnt == decim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= 4'd0;
    else if (pre_entry)
      div_cnt <= 4'd0;
    else if (wrt_smpl)
      div_cnt <= (div_cnt == decim) ? 4'd0 : div_cnt + 4'd1;
  end
`else
  assign strb = wrt_smpl;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; a dropped run wins over any write or completion.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (run)
          state_next = S_PRE;
      end
      S_PRE: begin
        if (!run)
          state_next = S_IDLE;
        else if ((q_eff == 17'd0) || (we_c && pre_hit))
          state_next = S_ARMED;
      end
      S_ARMED: begin
        if (!run)
          state_next = S_IDLE;
        else if (trig_acc)
          state_next = (p_eff == 17'd1) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (!run)
          state_next = S_IDLE;
        else if (we_c && post_hit)
          state_next = S_DONE;
      end
      S_DONE: begin
        if (!capture_done)
          state_next = (auto_rearm && run) ? S_PRE : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    busy_c = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    we_c   = strb && busy_c;
    done_c = 1'b0;
    if (state == S_ARMED)
      done_c = trig_acc && (p_eff == 17'd1);
    else if (state == S_POST)
      done_c = run && we_c && post_hit;
  end

  // Address, counters and trigger bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr     <= '0;
      trig_addr <= '0;
      armed     <= 1'b0;
      pre_cnt   <= 16'd0;
      post_cnt  <= 16'd0;
    end else begin
      armed <= (state_next == S_ARMED) || (state_next == S_POST);
      if ((state == S_IDLE) && (state_next == S_PRE)) begin
        waddr    <= '0;
        pre_cnt  <= 16'd0;
        post_cnt <= 16'd0;
      end else if ((state == S_DONE) && (state_next == S_PRE)) begin
        // Re-arm keeps waddr so the ring stays continuous.
        pre_cnt  <= 16'd0;
        post_cnt <= 16'd0;
      end else begin
        if (we_c)
          waddr <= wrap_inc(waddr);
        if ((state == S_PRE) && we_c)
          pre_cnt <= sat_inc16(pre_cnt);
        if (trig_acc) begin
          trig_addr <= waddr;
          post_cnt  <= 16'd1;
        end else if ((state == S_POST) && we_c) begin
          post_cnt <= post_cnt + 16'd1;
        end
      end
    end
  end

  assign cap.we               = we_c;
  assign cap.waddr            = waddr;
  assign cap.trig_addr        = trig_addr;
  assign cap.armed            = armed;
  assign cap.set_capture_done = done_c;
  assign cap.busy             = busy_c;

endmodule

// File: tb/tb_capture_ctrl_gen2.sv
// Scoreboard bench for capture_ctrl_gen2: per-cycle expectations queued by the driver.
module tb_capture_ctrl_gen2;
  localparam int ENTRIES = 384;
  localparam int AW      = 9;
  localparam int PW      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrt_smpl = 1'b0;
  logic          run = 1'b0;
  logic          auto_rearm = 1'b0;
  logic          triggered = 1'b0;
  logic          capture_done = 1'b0;
  logic [PW-1:0] trig_pos = '0;
`ifdef CAPTURE_DECIM_EN
  logic [3:0]    decim = 4'd0;
`endif

  capture_ctrl_gen2_if #(.AW(AW)) cap();

  capture_ctrl_gen2 #(.ENTRIES(ENTRIES), .AW(AW), .PW(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrt_smpl     (wrt_smpl),
    .run          (run),
    .auto_rearm   (auto_rearm),
    .triggered    (triggered),
    .capture_done (capture_done),
    .trig_pos     (trig_pos),
`ifdef CAPTURE_DECIM_EN
    .decim        (decim),
`endif
    .cap          (cap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    string tag;
    bit    we;
    bit    done;
    int    waddr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".we"}, 32'(cap.we), 32'(mon_e.we));
      check({mon_e.tag, ".done"}, 32'(cap.set_capture_done), 32'(mon_e.done));
      if (mon_e.waddr >= 0)
        check({mon_e.tag, ".waddr"}, 32'(cap.waddr), 32'(mon_e.waddr));
    end
  end

  // One clock cycle of stimulus; its expected outputs are queued for the monitor.
  task automatic cyc(input bit s, input bit t, input bit ew, input bit ed, input int ea,
                     input string tag);
    exp_t e;
    wrt_smpl = s;
    triggered = t;
    e.tag = tag;
    e.we = ew;
    e.done = ed;
    e.waddr = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0;
    triggered = 1'b0;
  endtask

  task automatic capture(input int tp, input int p, input int trig_i, input bit hold,
                         input bit rearm, input string tag);
    int q;
    int last;
    int fin;
    q = ENTRIES - p;
    last = trig_i + p - 1;
    fin = (trig_i + p) % ENTRIES;
    trig_pos = PW'(tp);
    auto_rearm = rearm;
    capture_done = 1'b0;
    run = 1'b1;
    cyc(1'b0, hold, 1'b0, 1'b0, -1, {tag, ".idle"});
    check({tag, ".armed_start"}, 32'(cap.armed), 32'd0);
    check({tag, ".busy_start"}, 32'(cap.busy), 32'd1);
    if (q == 0) begin
      cyc(1'b0, hold, 1'b0, 1'b0, 0, {tag, ".q0"});
      check({tag, ".armed_q0"}, 32'(cap.armed), 32'd1);
    end
    for (int i = 0; i <= last; i++) begin
      bit d;
      d = (i == last);
      capture_done = d;
      cyc(1'b1, hold || (i == trig_i), 1'b1, d, i % ENTRIES, tag);
      if (q >= 2 && i == q - 2)
        check({tag, ".armed_early"}, 32'(cap.armed), 32'd0);
      if (q >= 1 && i == q - 1)
        check({tag, ".armed_rise"}, 32'(cap.armed), 32'd1);
      if (i == trig_i)
        check({tag, ".trig_addr"}, 32'(cap.trig_addr), 32'(trig_i % ENTRIES));
    end
    check({tag, ".armed_end"}, 32'(cap.armed), 32'd0);
    check({tag, ".busy_end"}, 32'(cap.busy), 32'd0);
    check({tag, ".waddr_end"}, 32'(cap.waddr), 32'(fin));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, fin, {tag, ".done_hold"});
    check({tag, ".busy_hold"}, 32'(cap.busy), 32'd0);
    capture_done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, fin, {tag, ".release"});
    if (rearm) begin
      check({tag, ".busy_rearm"}, 32'(cap.busy), 32'd1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, fin, {tag, ".rearm_w0"});
      cyc(1'b1, 1'b0, 1'b1, 1'b0, (fin + 1) % ENTRIES, {tag, ".rearm_w1"});
      check({tag, ".armed_rearm"}, 32'(cap.armed), 32'd0);
      run = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, -1, {tag, ".stop"});
      check({tag, ".busy_stop"}, 32'(cap.busy), 32'd0);
    end else begin
      check({tag, ".busy_idle"}, 32'(cap.busy), 32'd0);
      run = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, fin, {tag, ".idle_hold"});
      check({tag, ".busy_idle2"}, 32'(cap.busy), 32'd0);
    end
  endtask

  initial begin
    // Reset state, including the combinational outputs with inputs active.
    wrt_smpl = 1'b1;
    run = 1'b1;
    triggered = 1'b1;
    #12;
    check("rst.we", 32'(cap.we), 32'd0);
    check("rst.busy", 32'(cap.busy), 32'd0);
    check("rst.done", 32'(cap.set_capture_done), 32'd0);
    check("rst.waddr", 32'(cap.waddr), 32'd0);
    check("rst.armed", 32'(cap.armed), 32'd0);
    check("rst.trig_addr", 32'(cap.trig_addr), 32'd0);
    wrt_smpl = 1'b0;
    run = 1'b0;
    triggered = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.stay_idle", 32'(cap.busy), 32'd0);

    capture(128, 128, 300, 1'b0, 1'b0, "nominal");
    capture(0, 1, 383, 1'b0, 1'b0, "p1");
    capture(400, 384, 0, 1'b0, 1'b0, "pfull");
    capture(128, 128, 256, 1'b1, 1'b0, "trig_held");
    capture(200, 200, 190, 1'b0, 1'b1, "rearm");

    // Abort during POST with post_cnt = 10.
    trig_pos = PW'(128);
    auto_rearm = 1'b0;
    run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, -1, "abort.idle");
    for (int i = 0; i < 266; i++)
      cyc(1'b1, i == 256, 1'b1, 1'b0, i, "abort");
    check("abort.armed_pre", 32'(cap.armed), 32'd1);
    run = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 266, "abort.last");
    check("abort.busy", 32'(cap.busy), 32'd0);
    check("abort.armed", 32'(cap.armed), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, -1, "abort.after");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, -1, "abort.after2");

    // Asynchronous reset mid-capture.
    run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, -1, "midrst.idle");
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 1'b1, 1'b0, i, "midrst");
    wrt_smpl = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst.we", 32'(cap.we), 32'd0);
    check("midrst.busy", 32'(cap.busy), 32'd0);
    check("midrst.waddr", 32'(cap.waddr), 32'd0);
    check("midrst.trig_addr", 32'(cap.trig_addr), 32'd0);
    check("midrst.done", 32'(cap.set_capture_done), 32'd0);
    wrt_smpl = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.idle_after", 32'(cap.busy), 32'd0);

`ifdef CAPTURE_DECIM_EN
    decim = 4'd3;
    trig_pos = PW'(128);
    run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, -1, "decim.idle");
    for (int k = 0; k < 40; k++)
      cyc(1'b1, 1'b0, (k % 4) == 3, 1'b0, k / 4, "decim");
    check("decim.waddr", 32'(cap.waddr), 32'd10);
    run = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, -1, "decim.stop");
    decim = 4'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
